// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and helpers for the matrix loader.
//   state_e          - loader state (LOAD accepting elements, HOLD presenting matrix)
//   N_DEF/DATA_W_DEF - default matrix dimension and element width
//   slot_idx()       - 1-based (row, col) to row-major flat slot index
package matrix_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int N_DEF      = 5;
    localparam int DATA_W_DEF = 32;

    function automatic int unsigned slot_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned n);
        return (row - 1) * n + (col - 1);
    endfunction

endpackage

// File: rtl/matrix_load_ctrl.sv
// matrix_load_ctrl: slot counter and LOAD/HOLD sequencing for matrix_loader.
//   clk_i, reset_i      - clock, synchronous active-high reset
//   clear_i             - abort current load / release held matrix
//   in_valid_i          - upstream element present
//   mat_ack_i           - consumer took the held matrix
//   in_ready_o          - state is LOAD
//   mat_valid_o         - state is HOLD
//   accept_o            - element written to slot count_o at this edge
//   restart_o           - count returns to 0 at this edge (clear or ack release)
//   count_o             - elements accepted in the current load
module matrix_load_ctrl
    import matrix_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic       in_valid_i,
    input  logic       mat_ack_i,
    output logic       in_ready_o,
    output logic       mat_valid_o,
    output logic       accept_o,
    output logic       restart_o,
    output logic [4:0] count_o
);

    localparam logic [4:0] LAST = 5'(N * N - 1);

    state_e     state_q, state_d;
    logic [4:0] count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        accept_o  = 1'b0;
        restart_o = 1'b0;
        unique case (state_q)
            LOAD: begin
                // clear wins over a same-cycle element; mat_ack has no effect here
                if (clear_i) begin
                    count_d   = '0;
                    restart_o = 1'b1;
                end else if (in_valid_i) begin
                    accept_o = 1'b1;
                    count_d  = count_q + 5'd1;
                    if (count_q == LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                if (clear_i || mat_ack_i) begin
                    state_d   = LOAD;
                    count_d   = '0;
                    restart_o = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // ready/valid decode from state only: no path from in_valid to in_ready
    assign in_ready_o  = (state_q == LOAD);
    assign mat_valid_o = (state_q == HOLD);
    assign count_o     = count_q;

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: collects N*N elements (row-major) into a register array and
// presents them as one flat vector until the consumer acknowledges.
//   clk, reset          - clock, synchronous active-high reset
//   clear               - abort partial load / release held matrix
//   in_valid/in_data    - element stream; in_ready high while loading
//   mat_valid/mat_flat  - complete matrix; element k at [k*DATA_W +: DATA_W]
//   mat_ack             - consumer took the matrix
//   count               - elements accepted in the current load
//   diag_zero           - a diagonal element loaded as zero
// Build option: define ZERO_DIAG_DETECT_EN to compile in diag_zero detection;
// otherwise diag_zero is tied to 0.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  mat_valid,
    input  logic                  mat_ack,
    output logic [N*N*DATA_W-1:0] mat_flat,
    output logic [4:0]            count,
    output logic                  diag_zero
);

    logic accept;
    logic restart;
    logic [N*N-1:0][DATA_W-1:0] mem_q;

    matrix_load_ctrl #(.N(N)) u_ctrl (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (clear),
        .in_valid_i (in_valid),
        .mat_ack_i  (mat_ack),
        .in_ready_o (in_ready),
        .mat_valid_o(mat_valid),
        .accept_o   (accept),
        .restart_o  (restart),
        .count_o    (count)
    );

    // one write decoder per slot; slots not written keep their old contents
    for (genvar k = 0; k < N * N; k++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset)
                mem_q[k] <= '0;
            else if (accept && (count == 5'(k)))
                mem_q[k] <= in_data;
        end
    end

    assign mat_flat = mem_q;

`ifdef ZERO_DIAG_DETECT_EN
    logic diag_q, diag_d;
    logic on_diag;

    always_comb begin
        on_diag = 1'b0;
        for (int r = 1; r <= N; r++)
            if (count == 5'(slot_idx(r, r, N))) on_diag = 1'b1;
    end

    always_comb begin
        diag_d = diag_q;
        if (restart)
            diag_d = 1'b0;
        else if (accept && on_diag && (in_data == '0))
            diag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) diag_q <= 1'b0;
        else       diag_q <= diag_d;
    end

    assign diag_zero = diag_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
    assign diag_zero      = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;
    localparam int DW  = 32;
    localparam int N   = 5;
    localparam int NN  = N * N;
    localparam int FW  = NN * DW;

`ifdef ZERO_DIAG_DETECT_EN
    localparam bit DIAG_EN = 1'b1;
`else
    localparam bit DIAG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, mat_ack;
    logic [DW-1:0] in_data;
    logic          in_ready, mat_valid, diag_zero;
    logic [FW-1:0] mat_flat;
    logic [4:0]    count;

    always #5 clk = ~clk;

    matrix_loader #(.DATA_W(DW), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mat_valid(mat_valid),
        .mat_ack  (mat_ack),
        .mat_flat (mat_flat),
        .count    (count),
        .diag_zero(diag_zero)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // reference model: matrix as an array of elements plus a load counter
    logic [DW-1:0] m_mat [NN];
    int            m_cnt;
    bit            m_full;
    bit            m_dz;

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NN; i++) f[i*DW +: DW] = m_mat[i];
        return f;
    endfunction

    task automatic m_step(input bit r, input bit c, input bit v, input logic [DW-1:0] d, input bit a);
        if (r) begin
            for (int i = 0; i < NN; i++) m_mat[i] = '0;
            m_cnt = 0; m_full = 0; m_dz = 0;
        end else if (!m_full) begin
            if (c) begin
                m_cnt = 0; m_dz = 0;
            end else if (v) begin
                m_mat[m_cnt] = d;
                if (DIAG_EN && d == 0 && (m_cnt % (N + 1)) == 0) m_dz = 1;
                m_cnt++;
                if (m_cnt == NN) m_full = 1;
            end
        end else if (c || a) begin
            m_full = 0; m_cnt = 0; m_dz = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdy"},  FW'(in_ready),  FW'(!m_full));
        chk({tag, ".vld"},  FW'(mat_valid), FW'(m_full));
        chk({tag, ".cnt"},  FW'(count),     FW'(m_cnt));
        chk({tag, ".flat"}, mat_flat,       m_flat());
        chk({tag, ".dz"},   FW'(diag_zero), FW'(m_dz));
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit v,
                        input logic [DW-1:0] d, input bit a);
        reset = r; clear = c; in_valid = v; in_data = d; mat_ack = a;
        @(posedge clk);
        m_step(r, c, v, d, a);
        #1;
        check_all(tag);
    endtask

    function automatic logic [DW-1:0] elem(input int row, input int col);
        return mat_flat[((row - 1) * N + (col - 1)) * DW +: DW];
    endfunction

    logic [FW-1:0] seq_flat;

    initial begin
        for (int i = 0; i < NN; i++) m_mat[i] = 'x;
        reset = 1; clear = 0; in_valid = 0; in_data = '0; mat_ack = 0;

        // reset state
        step("rst", 1, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0);

        // sequential load 1..25; HOLD must be visible right after the 25th accept
        for (int i = 1; i <= NN; i++) begin
            step("seq", 0, 0, 1, DW'(i), 0);
            chk("seq.lat", FW'(mat_valid), FW'(i == NN));
        end
        chk("seq.e11", FW'(elem(1, 1)), FW'(1));
        chk("seq.e34", FW'(elem(3, 4)), FW'(14));
        chk("seq.e55", FW'(elem(5, 5)), FW'(25));
        chk("seq.cnt", FW'(count), FW'(25));
        seq_flat = mat_flat;

        // back-pressure in HOLD
        for (int i = 0; i < 3; i++) begin
            step("bp", 0, 0, 1, 32'hDEADBEEF, 0);
            chk("bp.rdy", FW'(in_ready), FW'(0));
            chk("bp.flat", mat_flat, seq_flat);
        end
        step("bp.ack", 0, 0, 0, 0, 1);
        chk("bp.ack.cnt", FW'(count), FW'(0));
        chk("bp.ack.rdy", FW'(in_ready), FW'(1));

        // mat_ack in LOAD ignored
        step("ackload", 0, 0, 1, 32'd100, 1);
        step("rst2", 1, 0, 0, 0, 0);

        // gapped valid: same matrix as back-to-back
        for (int i = 1; i <= NN; ) begin
            step("gap.v", 0, 0, 1, DW'(i), 0);
            i++;
            if (i <= NN) step("gap.n", 0, 0, 0, 32'hFFFF_FFFF, 0);
        end
        chk("gap.flat", mat_flat, seq_flat);
        step("gap.ack", 0, 0, 0, 0, 1);

        // clear mid-load with a same-cycle element
        for (int i = 0; i < 10; i++) step("clr.pre", 0, 0, 1, DW'(200 + i), 0);
        step("clr", 0, 1, 1, 32'h55, 0);
        chk("clr.cnt", FW'(count), FW'(0));
        chk("clr.s0", FW'(elem(1, 1)), FW'(200));
        for (int i = 0; i < NN; i++) step("clr.load", 0, 0, 1, DW'(300 + i), 0);
        chk("clr.s0b", FW'(elem(1, 1)), FW'(300));
        step("clr.hold", 0, 1, 0, 0, 1);   // clear together with ack

        // reset mid-load
        for (int i = 0; i < 7; i++) step("rml.pre", 0, 0, 1, DW'(i + 9), 0);
        step("rml", 1, 1, 1, 32'h77, 1);
        chk("rml.flat", mat_flat, '0);
        chk("rml.vld", FW'(mat_valid), FW'(0));
        for (int i = 0; i < NN; i++) step("rml.load", 0, 0, 1, $urandom, 0);
        chk("rml.done", FW'(mat_valid), FW'(1));
        step("rml.ack", 0, 0, 0, 0, 1);

        // identity with (3,3)=0, then full identity
        for (int i = 0; i < NN; i++)
            step("dz1", 0, 0, 1, DW'((i % (N + 1)) == 0 && i != 12), 0);
        chk("dz1.flag", FW'(diag_zero), FW'(DIAG_EN));
        step("dz1.ack", 0, 0, 0, 0, 1);
        for (int i = 0; i < NN; i++)
            step("dz2", 0, 0, 1, DW'((i % (N + 1)) == 0), 0);
        chk("dz2.flag", FW'(diag_zero), FW'(0));
        step("dz2.ack", 0, 0, 0, 0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit r, c, v, a;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 9) < 3);
            d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            step("rnd", r, c, v, d, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
